// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the data stage.
// Data requests win by default; a starvation counter forces a fetch grant after
// STARVE_MAX consecutive fetch losses. A redirect squashes an in-flight fetch.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              IF_Req,
    input  logic [ADDR_W-1:0] IF_Addr,
    input  logic              IF_Flush,
    output logic [DATA_W-1:0] IF_Data,
    output logic [1:0]        IF_Valid,
    input  logic              D_Req,
    input  logic              D_Write,
    input  logic [ADDR_W-1:0] D_Addr,
    input  logic [DATA_W-1:0] D_WData,
    output logic [DATA_W-1:0] D_RData,
    output logic              D_Done,
    output logic              Mem_Req,
    output logic              Mem_Write,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [DATA_W-1:0] Mem_WData,
    input  logic [DATA_W-1:0] Mem_RData,
    input  logic              Mem_Ack
);

    localparam int unsigned STARVE_W = 4;
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    localparam logic [1:0] IFV_WAIT   = 2'd0;
    localparam logic [1:0] IFV_VALID  = 2'd1;
    localparam logic [1:0] IFV_FLIGHT = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2,
        RESP    = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    state_t              state_q,     state_d;
    owner_t              owner_q,     owner_d;
    logic [STARVE_W-1:0] starve_q,    starve_d;
    logic                squash_q,    squash_d;
    logic                mem_req_q,   mem_req_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   if_data_q,   if_data_d;
    logic [1:0]          if_valid_q,  if_valid_d;
    logic [DATA_W-1:0]   d_rdata_q,   d_rdata_d;
    logic                d_done_q,    d_done_d;

    // Next-state: arbitration in IDLE, wait for ack in BUSY, one response cycle.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        starve_d    = starve_q;
        squash_d    = squash_q;
        mem_req_d   = mem_req_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_data_d   = if_data_q;
        if_valid_d  = if_valid_q;
        d_rdata_d   = d_rdata_q;
        d_done_d    = d_done_q;

        case (state_q)
            IDLE: begin
                if (D_Req && !(IF_Req && (starve_q == STARVE_LIM))) begin
                    state_d     = BUSY_D;
                    owner_d     = OWN_D;
                    mem_req_d   = 1'b1;
                    mem_write_d = D_Write;
                    mem_addr_d  = D_Addr;
                    mem_wdata_d = D_WData;
                    if_valid_d  = IFV_WAIT;
                    if (IF_Req && (starve_q < STARVE_LIM)) begin
                        starve_d = starve_q + STARVE_W'(1);
                    end
                end else if (IF_Req && !IF_Flush) begin
                    state_d     = BUSY_IF;
                    owner_d     = OWN_IF;
                    mem_req_d   = 1'b1;
                    mem_write_d = 1'b0;
                    mem_addr_d  = IF_Addr;
                    mem_wdata_d = '0;
                    if_valid_d  = IFV_FLIGHT;
                    starve_d    = '0;
                end
            end
            BUSY_IF: begin
                if (IF_Flush) begin
                    squash_d = 1'b1;
                end
                if (Mem_Ack) begin
                    state_d    = RESP;
                    mem_req_d  = 1'b0;
                    if_data_d  = Mem_RData;
                    if_valid_d = (squash_q || IF_Flush) ? IFV_WAIT : IFV_VALID;
                end
            end
            BUSY_D: begin
                if (Mem_Ack) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    d_rdata_d = Mem_RData;
                    d_done_d  = 1'b1;
                end
            end
            RESP: begin
                state_d    = IDLE;
                d_done_d   = 1'b0;
                if_valid_d = IFV_WAIT;
                squash_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            starve_q    <= '0;
            squash_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_data_q   <= '0;
            if_valid_q  <= IFV_WAIT;
            d_rdata_q   <= '0;
            d_done_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            squash_q    <= squash_d;
            mem_req_q   <= mem_req_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_data_q   <= if_data_d;
            if_valid_q  <= if_valid_d;
            d_rdata_q   <= d_rdata_d;
            d_done_q    <= d_done_d;
        end
    end

    assign IF_Data   = if_data_q;
    assign IF_Valid  = if_valid_q;
    assign D_RData   = d_rdata_q;
    assign D_Done    = d_done_q;
    assign Mem_Req   = mem_req_q;
    assign Mem_Write = mem_write_q;
    assign Mem_Addr  = mem_addr_q;
    assign Mem_WData = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store, starvation, squash, reset.
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        IF_Req;
    logic [31:0] IF_Addr;
    logic        IF_Flush;
    logic [31:0] IF_Data;
    logic [1:0]  IF_Valid;
    logic        D_Req;
    logic        D_Write;
    logic [31:0] D_Addr;
    logic [31:0] D_WData;
    logic [31:0] D_RData;
    logic        D_Done;
    logic        Mem_Req;
    logic        Mem_Write;
    logic [31:0] Mem_Addr;
    logic [31:0] Mem_WData;
    logic [31:0] Mem_RData;
    logic        Mem_Ack;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .IF_Req(IF_Req), .IF_Addr(IF_Addr), .IF_Flush(IF_Flush),
        .IF_Data(IF_Data), .IF_Valid(IF_Valid),
        .D_Req(D_Req), .D_Write(D_Write), .D_Addr(D_Addr), .D_WData(D_WData),
        .D_RData(D_RData), .D_Done(D_Done),
        .Mem_Req(Mem_Req), .Mem_Write(Mem_Write), .Mem_Addr(Mem_Addr),
        .Mem_WData(Mem_WData), .Mem_RData(Mem_RData), .Mem_Ack(Mem_Ack)
    );

    always #5 CLK = ~CLK;

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1; IF_Req = 1'b0; IF_Addr = '0; IF_Flush = 1'b0;
        D_Req = 1'b0; D_Write = 1'b0; D_Addr = '0; D_WData = '0;
        Mem_RData = '0; Mem_Ack = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (IF_Data !== 32'h0)   begin errors++; $display("FAIL reset_if_data got %h want 0", IF_Data); end
        checks++; if (IF_Valid !== 2'd0)   begin errors++; $display("FAIL reset_if_valid got %0d want 0", IF_Valid); end
        checks++; if (D_RData !== 32'h0)   begin errors++; $display("FAIL reset_d_rdata got %h want 0", D_RData); end
        checks++; if (D_Done !== 1'b0)     begin errors++; $display("FAIL reset_d_done got %b want 0", D_Done); end
        checks++; if (Mem_Req !== 1'b0)    begin errors++; $display("FAIL reset_mem_req got %b want 0", Mem_Req); end
        checks++; if (Mem_Write !== 1'b0)  begin errors++; $display("FAIL reset_mem_write got %b want 0", Mem_Write); end
        checks++; if (Mem_Addr !== 32'h0)  begin errors++; $display("FAIL reset_mem_addr got %h want 0", Mem_Addr); end
        checks++; if (Mem_WData !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got %h want 0", Mem_WData); end
        RESET = 1'b0;
        cyc();
        cyc();
        checks++; if (Mem_Req !== 1'b0)  begin errors++; $display("FAIL idle_mem_req got %b want 0", Mem_Req); end
        checks++; if (IF_Valid !== 2'd0) begin errors++; $display("FAIL idle_if_valid got %0d want 0", IF_Valid); end
    endtask

    task automatic test_if_fetch();
        IF_Req = 1'b1; IF_Addr = 32'hBFC0_0000;
        cyc();  // granted; Mem_Req now high
        checks++; if (Mem_Req !== 1'b1)          begin errors++; $display("FAIL fetch_mem_req got %b want 1", Mem_Req); end
        checks++; if (Mem_Addr !== 32'hBFC0_0000) begin errors++; $display("FAIL fetch_mem_addr got %h want bfc00000", Mem_Addr); end
        checks++; if (Mem_Write !== 1'b0)        begin errors++; $display("FAIL fetch_mem_write got %b want 0", Mem_Write); end
        checks++; if (IF_Valid !== 2'd2)         begin errors++; $display("FAIL fetch_busy1 got %0d want 2", IF_Valid); end
        cyc();
        checks++; if (IF_Valid !== 2'd2)         begin errors++; $display("FAIL fetch_busy2 got %0d want 2", IF_Valid); end
        checks++; if (Mem_Req !== 1'b1)          begin errors++; $display("FAIL fetch_req_hold got %b want 1", Mem_Req); end
        Mem_Ack = 1'b1; Mem_RData = 32'h3C1D_A000;
        cyc();  // response cycle
        Mem_Ack = 1'b0; Mem_RData = '0;
        checks++; if (IF_Valid !== 2'd1)         begin errors++; $display("FAIL fetch_valid got %0d want 1", IF_Valid); end
        checks++; if (IF_Data !== 32'h3C1D_A000) begin errors++; $display("FAIL fetch_data got %h want 3c1da000", IF_Data); end
        checks++; if (Mem_Req !== 1'b0)          begin errors++; $display("FAIL fetch_req_drop got %b want 0", Mem_Req); end
        IF_Req = 1'b0;
        cyc();
        checks++; if (IF_Valid !== 2'd0)         begin errors++; $display("FAIL fetch_valid_end got %0d want 0", IF_Valid); end
        cyc();
        checks++; if (Mem_Req !== 1'b0)          begin errors++; $display("FAIL fetch_no_regrant got %b want 0", Mem_Req); end
    endtask

    task automatic test_d_store();
        D_Req = 1'b1; D_Write = 1'b1; D_Addr = 32'hA000_0010; D_WData = 32'hDEAD_BEEF;
        cyc();
        checks++; if (Mem_Req !== 1'b1)           begin errors++; $display("FAIL store_mem_req got %b want 1", Mem_Req); end
        checks++; if (Mem_Write !== 1'b1)         begin errors++; $display("FAIL store_mem_write got %b want 1", Mem_Write); end
        checks++; if (Mem_Addr !== 32'hA000_0010) begin errors++; $display("FAIL store_mem_addr got %h want a0000010", Mem_Addr); end
        checks++; if (Mem_WData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_mem_wdata got %h want deadbeef", Mem_WData); end
        checks++; if (IF_Valid !== 2'd0)          begin errors++; $display("FAIL store_if_valid got %0d want 0", IF_Valid); end
        checks++; if (D_Done !== 1'b0)            begin errors++; $display("FAIL store_early_done got %b want 0", D_Done); end
        Mem_Ack = 1'b1;
        cyc();
        Mem_Ack = 1'b0;
        checks++; if (D_Done !== 1'b1)            begin errors++; $display("FAIL store_done got %b want 1", D_Done); end
        checks++; if (Mem_Req !== 1'b0)           begin errors++; $display("FAIL store_req_drop got %b want 0", Mem_Req); end
        D_Req = 1'b0; D_Write = 1'b0;
        cyc();
        checks++; if (D_Done !== 1'b0)            begin errors++; $display("FAIL store_done_pulse got %b want 0", D_Done); end
        cyc();
        checks++; if (D_Done !== 1'b0)            begin errors++; $display("FAIL store_done_once got %b want 0", D_Done); end
    endtask

    task automatic test_starvation();
        bit exp_d [6];
        logic [31:0] exp_addr;
        logic [31:0] rdata;
        bit found;
        exp_d[0] = 1'b1; exp_d[1] = 1'b1; exp_d[2] = 1'b1;
        exp_d[3] = 1'b1; exp_d[4] = 1'b0; exp_d[5] = 1'b1;
        IF_Req = 1'b1; IF_Addr = 32'hBFC0_0200;
        D_Req = 1'b1; D_Write = 1'b0; D_Addr = 32'h8000_0100;
        for (int g = 0; g < 6; g++) begin
            found = 1'b0;
            for (int w = 0; w < 8 && !found; w++) begin
                cyc();
                if (Mem_Req === 1'b1) found = 1'b1;
            end
            checks++; if (!found) begin errors++; $display("FAIL starve_grant%0d got no Mem_Req want grant", g); end
            exp_addr = exp_d[g] ? 32'h8000_0100 : 32'hBFC0_0200;
            checks++; if (Mem_Addr !== exp_addr) begin errors++; $display("FAIL starve_owner%0d got %h want %h", g, Mem_Addr, exp_addr); end
            checks++; if (IF_Valid !== (exp_d[g] ? 2'd0 : 2'd2)) begin errors++; $display("FAIL starve_busy_valid%0d got %0d", g, IF_Valid); end
            rdata = 32'h1000_0000 + 32'(g);
            Mem_Ack = 1'b1; Mem_RData = rdata;
            cyc();
            Mem_Ack = 1'b0;
            if (exp_d[g]) begin
                checks++; if (D_Done !== 1'b1 || D_RData !== rdata) begin errors++; $display("FAIL starve_d_resp%0d got done=%b data=%h want 1 %h", g, D_Done, D_RData, rdata); end
            end else begin
                checks++; if (IF_Valid !== 2'd1 || IF_Data !== rdata) begin errors++; $display("FAIL starve_if_resp%0d got valid=%0d data=%h want 1 %h", g, IF_Valid, IF_Data, rdata); end
            end
        end
        IF_Req = 1'b0; D_Req = 1'b0;
        cyc();
        cyc();
        checks++; if (Mem_Req !== 1'b0) begin errors++; $display("FAIL starve_quiet got %b want 0", Mem_Req); end
    endtask

    task automatic test_flush_busy();
        IF_Req = 1'b1; IF_Addr = 32'hBFC0_0008;
        cyc();
        checks++; if (Mem_Addr !== 32'hBFC0_0008 || IF_Valid !== 2'd2) begin errors++; $display("FAIL flush_grant got addr=%h valid=%0d want bfc00008 2", Mem_Addr, IF_Valid); end
        IF_Flush = 1'b1;
        cyc();
        IF_Flush = 1'b0; IF_Addr = 32'hBFC0_0100;
        checks++; if (IF_Valid !== 2'd2 || Mem_Req !== 1'b1) begin errors++; $display("FAIL flush_still_busy got valid=%0d req=%b want 2 1", IF_Valid, Mem_Req); end
        Mem_Ack = 1'b1; Mem_RData = 32'h1234_5678;
        cyc();
        Mem_Ack = 1'b0;
        checks++; if (IF_Valid !== 2'd0) begin errors++; $display("FAIL flush_squashed got %0d want 0", IF_Valid); end
        checks++; if (Mem_Req !== 1'b0)  begin errors++; $display("FAIL flush_req_drop got %b want 0", Mem_Req); end
        cyc();
        checks++; if (Mem_Req !== 1'b0)  begin errors++; $display("FAIL flush_no_resp_grant got %b want 0", Mem_Req); end
        cyc();
        checks++; if (Mem_Addr !== 32'hBFC0_0100 || IF_Valid !== 2'd2) begin errors++; $display("FAIL flush_refetch got addr=%h valid=%0d want bfc00100 2", Mem_Addr, IF_Valid); end
        Mem_Ack = 1'b1; Mem_RData = 32'hCAFE_0001;
        cyc();
        Mem_Ack = 1'b0;
        checks++; if (IF_Valid !== 2'd1 || IF_Data !== 32'hCAFE_0001) begin errors++; $display("FAIL flush_refetch_data got valid=%0d data=%h want 1 cafe0001", IF_Valid, IF_Data); end
        IF_Req = 1'b0;
        cyc();
    endtask

    task automatic test_flush_idle();
        IF_Req = 1'b1; IF_Flush = 1'b1; IF_Addr = 32'hBFC0_0300;
        cyc();
        checks++; if (Mem_Req !== 1'b0 || IF_Valid !== 2'd0) begin errors++; $display("FAIL idle_flush_block got req=%b valid=%0d want 0 0", Mem_Req, IF_Valid); end
        IF_Flush = 1'b0;
        cyc();
        checks++; if (Mem_Req !== 1'b1 || Mem_Addr !== 32'hBFC0_0300) begin errors++; $display("FAIL idle_flush_release got req=%b addr=%h want 1 bfc00300", Mem_Req, Mem_Addr); end
        Mem_Ack = 1'b1; Mem_RData = 32'h0000_00AA;
        cyc();
        Mem_Ack = 1'b0;
        checks++; if (IF_Valid !== 2'd1) begin errors++; $display("FAIL idle_flush_valid got %0d want 1", IF_Valid); end
        IF_Req = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid_op();
        D_Req = 1'b1; D_Write = 1'b1; D_Addr = 32'hA000_0020; D_WData = 32'h5555_AAAA;
        cyc();
        checks++; if (Mem_Req !== 1'b1) begin errors++; $display("FAIL midrst_busy got %b want 1", Mem_Req); end
        RESET = 1'b1; D_Req = 1'b0; D_Write = 1'b0;
        cyc();
        RESET = 1'b0;
        checks++; if (Mem_Req !== 1'b0 || Mem_Write !== 1'b0 || Mem_Addr !== 32'h0 || Mem_WData !== 32'h0)
            begin errors++; $display("FAIL midrst_mem got req=%b we=%b addr=%h wd=%h want all 0", Mem_Req, Mem_Write, Mem_Addr, Mem_WData); end
        checks++; if (D_Done !== 1'b0 || D_RData !== 32'h0 || IF_Valid !== 2'd0 || IF_Data !== 32'h0)
            begin errors++; $display("FAIL midrst_out got done=%b rd=%h v=%0d id=%h want all 0", D_Done, D_RData, IF_Valid, IF_Data); end
        Mem_Ack = 1'b1; Mem_RData = 32'hFFFF_FFFF;
        cyc();
        Mem_Ack = 1'b0;
        checks++; if (D_Done !== 1'b0 || Mem_Req !== 1'b0) begin errors++; $display("FAIL midrst_stray1 got done=%b req=%b want 0 0", D_Done, Mem_Req); end
        cyc();
        checks++; if (D_Done !== 1'b0 || D_RData !== 32'h0) begin errors++; $display("FAIL midrst_stray2 got done=%b rd=%h want 0 0", D_Done, D_RData); end
    endtask

    initial begin
        test_reset();
        test_if_fetch();
        test_d_store();
        test_starvation();
        test_flush_busy();
        test_flush_idle();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
